light_hash_par: RTL and testbench
=================================

LIGHT_HASH_PAR -- requirements
Module: light_hash_par

Interface
REQ-001 SHALL provide parameter N_LANES, default 8, meaning the number of 8-bit state lanes, so the digest width is 8*N_LANES; legal range 2..32.
REQ-002 SHALL provide parameter N_ROUNDS, default 32, meaning the rounds per absorbed byte; legal range 1..255.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL provide port msg_byte, input, 8 bits: the message byte, sampled only with cmd MESSAGE.
REQ-006 SHALL provide port msg_cmd, input, 2 bits: the command; HEAD=00, TAIL=01, MESSAGE=10, 11 reserved.
REQ-007 SHALL provide port msg_valid, input, 1 bit: the command/byte is valid.
REQ-008 SHALL provide port msg_ready, output, 1 bit: the block can accept a command.
REQ-009 SHALL provide port digest, output, 8*N_LANES bits: the final hash, with lane 0 in bits [7:0].
REQ-010 SHALL provide port digest_ready, output, 1 bit: the digest holds the result of the last completed TAIL.

Function
REQ-011 SHALL transfer a command only on an edge where msg_valid=1 and msg_ready=1; msg_valid without msg_ready is ignored.
REQ-012 SHALL use the FSM states IDLE, ABSORB, PAD and DONE, with msg_ready=1 only in IDLE and DONE.
REQ-013 SHALL define the state H[0..N_LANES-1] as 8-bit lanes with IV lane i = (8'h0F + i*8'h11) mod 256.
REQ-014 SHALL, on HEAD: set H=IV, set the byte counter to 0, clear digest_ready, go to IDLE, and leave digest unchanged.
REQ-015 SHALL, on MESSAGE: latch M=msg_byte, increment the 8-bit counter (wrapping 255->0), and go to ABSORB.
REQ-016 SHALL, in ABSORB round r (0..N_ROUNDS-1), compute Mr = rotl8(M, r mod 8) XOR r[7:0].
REQ-017 SHALL, in ABSORB round r, update every lane in parallel as H'[i] = SBOX(H[(i+1) mod N_LANES] XOR Mr) XOR rotl8(H[i],1).
REQ-018 SHALL execute one round per clock; for a byte accepted at edge k, rounds occur at edges k+1..k+N_ROUNDS and msg_ready returns to 1 after edge k+N_ROUNDS.
REQ-019 SHALL, on TAIL, clear digest_ready and then proceed per the Configuration section; on completion latch digest=H, set digest_ready=1 and go to DONE.
REQ-020 SHALL hold digest and digest_ready stable in DONE until the next accepted command, and clear digest_ready on any accepted command.
REQ-021 SHALL, on MESSAGE accepted in DONE, continue absorbing from the current H without re-initialising.
REQ-022 SHALL accept MESSAGE in IDLE after reset without a HEAD, because H=IV at reset.
REQ-023 SHALL accept cmd 11 and ignore it, with no change to state, H, counter or outputs.
REQ-024 SHALL implement SBOX as the standard AES forward S-box.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-ABSORB or mid-PAD, immediately set: state IDLE, H=IV, counter 0, digest 0, digest_ready 0, msg_ready 1.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst_n is deasserted.

Configuration
REQ-027 SHALL use the macro LIGHT_HASH_LEN_PAD_EN; when it is defined, TAIL enters PAD and absorbs M=counter for N_ROUNDS rounds using the REQ-016/017 rules.
REQ-028 SHALL, with LIGHT_HASH_LEN_PAD_EN defined, latch the digest at the last PAD edge, so that for TAIL at edge k, digest_ready=1 after edge k+N_ROUNDS.
REQ-029 SHALL, without LIGHT_HASH_LEN_PAD_EN, compile out the PAD state and latch digest=H at edge k+1 for TAIL at edge k.

Structure
REQ-030 SHALL place in package light_hash_pkg: the cmd enum (HEAD/TAIL/MESSAGE/RSVD), the FSM state enum, the IV function, and the default N_LANES/N_ROUNDS constants.
REQ-031 SHALL use sub-module lh_aes_sbox (8-bit in, 8-bit out, combinational), instantiated N_LANES times via generate.

Verification
REQ-032 SHALL cover: reset, then HEAD, then TAIL with no message bytes -> digest equals the model's value for the empty message (IV unchanged if pad is off); digest_ready rises exactly 1 cycle after TAIL (pad off) or N_ROUNDS cycles after it (pad on).
REQ-033 SHALL cover: "abc" with N_LANES=8, N_ROUNDS=32 -> msg_ready low for exactly 32 cycles per byte; digest matches the C/Python golden model.
REQ-034 SHALL cover: N_LANES=16, N_ROUNDS=4, 300-byte message -> counter wraps to 44; the 128-bit digest matches the model.
REQ-035 SHALL cover: msg_valid held high during ABSORB with changing msg_byte -> no extra bytes absorbed, and the digest is unaffected.
REQ-036 SHALL cover: rst_n pulsed low mid-ABSORB -> outputs 0/0/1 asynchronously, and a following HEAD+"x"+TAIL gives the model digest.
REQ-037 SHALL cover: cmd 11 inserted between bytes, and HEAD issued in DONE -> the digest is unchanged by cmd 11, and digest_ready falls on HEAD.

Source files
------------

// File: rtl/light_hash_pkg.sv
// Shared types, constants and helpers for the light_hash_par hash core.
// Defining LIGHT_HASH_LEN_PAD_EN adds the PAD state, which absorbs the byte count on TAIL.
package light_hash_pkg;

    localparam int DEFAULT_N_LANES  = 8;
    localparam int DEFAULT_N_ROUNDS = 32;

    typedef enum logic [1:0] {
        HEAD    = 2'b00,
        TAIL    = 2'b01,
        MESSAGE = 2'b10,
        RSVD    = 2'b11
    } cmd_e;

`ifdef LIGHT_HASH_LEN_PAD_EN
    typedef enum logic [1:0] {IDLE, ABSORB, PAD, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, ABSORB, DONE} state_e;
`endif

    function automatic logic [7:0] iv_lane(input int unsigned idx);
        return 8'h0F + 8'(idx * 32'h11);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] sh);
        return (x << sh) | (x >> (4'd8 - {1'b0, sh}));
    endfunction

endpackage

// File: rtl/light_hash_par_sbox.sv
// AES forward S-box as a purely combinational lookup; one instance per state lane.
module lh_aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/light_hash_par.sv
// Parallel-lane lightweight hash: one round per clock over N_LANES 8-bit lanes mixed through AES S-boxes.
// Optional feature macro LIGHT_HASH_LEN_PAD_EN: TAIL absorbs the byte count before the digest is latched.
module light_hash_par
    import light_hash_pkg::*;
#(
    parameter int N_LANES  = DEFAULT_N_LANES,
    parameter int N_ROUNDS = DEFAULT_N_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           msg_byte,
    input  logic [1:0]           msg_cmd,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    output logic [8*N_LANES-1:0] digest,
    output logic                 digest_ready
);

    state_e               r_state;
    state_e               w_state_next;
    logic [7:0]           r_h        [N_LANES];
    logic [7:0]           w_h_next   [N_LANES];
    logic [7:0]           w_sbox_in  [N_LANES];
    logic [7:0]           w_sbox_out [N_LANES];
    logic [7:0]           r_m;
    logic [7:0]           r_count;
    logic [7:0]           r_round;
    logic [7:0]           w_mr;
    logic [8*N_LANES-1:0] r_digest;
    logic [8*N_LANES-1:0] w_digest_src;
    logic                 r_digest_ready;
    logic                 w_accept;
    logic                 w_last_round;
    logic                 w_rounding;
    cmd_e                 w_cmd;
`ifndef LIGHT_HASH_LEN_PAD_EN
    // Without padding the digest is taken one edge after TAIL; this flag covers that gap.
    logic                 r_tail_pend;
`endif

    assign w_cmd        = cmd_e'(msg_cmd);
    assign w_accept     = msg_valid && msg_ready;
    assign w_last_round = (r_round == 8'(N_ROUNDS - 1));
    assign w_mr         = rotl8(r_m, r_round[2:0]) ^ r_round;

`ifdef LIGHT_HASH_LEN_PAD_EN
    assign msg_ready  = (r_state == IDLE) || (r_state == DONE);
    assign w_rounding = (r_state == ABSORB) || (r_state == PAD);
`else
    assign msg_ready  = ((r_state == IDLE) || (r_state == DONE)) && !r_tail_pend;
    assign w_rounding = (r_state == ABSORB);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign w_sbox_in[gi] = r_h[(gi + 1) % N_LANES] ^ w_mr;
            lh_aes_sbox u_sbox (
                .i_byte (w_sbox_in[gi]),
                .o_byte (w_sbox_out[gi])
            );
            assign w_h_next[gi] = w_sbox_out[gi] ^ rotl8(r_h[gi], 3'd1);
`ifdef LIGHT_HASH_LEN_PAD_EN
            assign w_digest_src[8*gi +: 8] = w_h_next[gi];
`else
            assign w_digest_src[8*gi +: 8] = r_h[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    case (w_cmd)
                        HEAD:    w_state_next = IDLE;
                        MESSAGE: w_state_next = ABSORB;
`ifdef LIGHT_HASH_LEN_PAD_EN
                        TAIL:    w_state_next = PAD;
`endif
                        default: w_state_next = r_state;
                    endcase
                end
`ifndef LIGHT_HASH_LEN_PAD_EN
                if (r_tail_pend) begin
                    w_state_next = DONE;
                end
`endif
            end
            ABSORB: begin
                if (w_last_round) begin
                    w_state_next = IDLE;
                end
            end
`ifdef LIGHT_HASH_LEN_PAD_EN
            PAD: begin
                if (w_last_round) begin
                    w_state_next = DONE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                r_h[i] <= iv_lane(i);
            end
            r_m            <= 8'd0;
            r_count        <= 8'd0;
            r_round        <= 8'd0;
            r_digest       <= '0;
            r_digest_ready <= 1'b0;
`ifndef LIGHT_HASH_LEN_PAD_EN
            r_tail_pend    <= 1'b0;
`endif
        end else begin
`ifndef LIGHT_HASH_LEN_PAD_EN
            r_tail_pend <= 1'b0;
`endif
            if (w_accept) begin
                case (w_cmd)
                    HEAD: begin
                        for (int unsigned i = 0; i < N_LANES; i++) begin
                            r_h[i] <= iv_lane(i);
                        end
                        r_count        <= 8'd0;
                        r_digest_ready <= 1'b0;
                    end
                    MESSAGE: begin
                        r_m            <= msg_byte;
                        r_count        <= r_count + 8'd1;
                        r_round        <= 8'd0;
                        r_digest_ready <= 1'b0;
                    end
                    TAIL: begin
                        r_round        <= 8'd0;
                        r_digest_ready <= 1'b0;
`ifdef LIGHT_HASH_LEN_PAD_EN
                        r_m            <= r_count;
`else
                        r_tail_pend    <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
            if (w_rounding) begin
                r_h     <= w_h_next;
                r_round <= r_round + 8'd1;
            end
`ifdef LIGHT_HASH_LEN_PAD_EN
            if ((r_state == PAD) && w_last_round) begin
                r_digest       <= w_digest_src;
                r_digest_ready <= 1'b1;
            end
`else
            if (r_tail_pend) begin
                r_digest       <= w_digest_src;
                r_digest_ready <= 1'b1;
            end
`endif
        end
    end

    assign digest       = r_digest;
    assign digest_ready = r_digest_ready;

endmodule

// File: tb/tb_light_hash_par.sv
// Directed bench for light_hash_par: a default 8-lane/32-round instance and a 16-lane/4-round instance.
// Expected digests come from a behavioural model whose S-box is derived from GF(2^8) inversion.
`timescale 1ns/1ps
module tb_light_hash_par;
    import light_hash_pkg::*;

`ifdef LIGHT_HASH_LEN_PAD_EN
    localparam int LAT_A = 32;
    localparam int LAT_B = 4;
`else
    localparam int LAT_A = 1;
    localparam int LAT_B = 1;
`endif

    logic         clk = 1'b0;
    logic         rstnA, rstnB;
    logic         validA, validB;
    logic [1:0]   cmdA, cmdB;
    logic [7:0]   byteA, byteB;
    logic         readyA, readyB;
    logic [63:0]  digestA;
    logic [127:0] digestB;
    logic         dreadyA, dreadyB;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [7:0] sboxTab [256];
    logic [7:0] mH [32];
    logic [7:0] mCnt;
    int         mLanes;
    int         mRounds;

    light_hash_par dutA (
        .clk          (clk),
        .rst_n        (rstnA),
        .msg_byte     (byteA),
        .msg_cmd      (cmdA),
        .msg_valid    (validA),
        .msg_ready    (readyA),
        .digest       (digestA),
        .digest_ready (dreadyA)
    );

    light_hash_par #(.N_LANES(16), .N_ROUNDS(4)) dutB (
        .clk          (clk),
        .rst_n        (rstnB),
        .msg_byte     (byteB),
        .msg_cmd      (cmdB),
        .msg_valid    (validB),
        .msg_ready    (readyB),
        .digest       (digestB),
        .digest_ready (dreadyB)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotlModel(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int k = 0; k < n; k++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gfMul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sboxTab[v] = inv ^ rotlModel(inv, 1) ^ rotlModel(inv, 2) ^ rotlModel(inv, 3)
                         ^ rotlModel(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic modelInit(input int lanes, input int rounds);
        mLanes = lanes;
        mRounds = rounds;
        mCnt = 8'd0;
        for (int i = 0; i < 32; i++) mH[i] = 8'(15 + 17 * i);
    endtask

    task automatic modelRounds(input logic [7:0] m);
        logic [7:0] nh [32];
        logic [7:0] mr;
        for (int r = 0; r < mRounds; r++) begin
            mr = rotlModel(m, r % 8) ^ 8'(r);
            for (int i = 0; i < mLanes; i++)
                nh[i] = sboxTab[mH[(i + 1) % mLanes] ^ mr] ^ rotlModel(mH[i], 1);
            for (int i = 0; i < mLanes; i++) mH[i] = nh[i];
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        mCnt = mCnt + 8'd1;
        modelRounds(b);
    endtask

    task automatic modelTail();
`ifdef LIGHT_HASH_LEN_PAD_EN
        modelRounds(mCnt);
`endif
    endtask

    function automatic logic [127:0] modelDigest();
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < mLanes; i++) d[8*i +: 8] = mH[i];
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for msg_ready, then presents one command for exactly one accepting edge.
    task automatic applyStimulus(input bit toB, input logic [1:0] cmd, input logic [7:0] dataByte);
        int waitCycles = 0;
        @(negedge clk);
        while (!(toB ? readyB : readyA) && waitCycles < 2000) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("readyBeforeCmd", 128'(toB ? readyB : readyA), 128'(1));
        if (toB) begin
            validB = 1'b1; cmdB = cmd; byteB = dataByte;
        end else begin
            validA = 1'b1; cmdA = cmd; byteA = dataByte;
        end
        @(posedge clk);
        #1;
        validA = 1'b0;
        validB = 1'b0;
    endtask

    task automatic sendByte(input bit toB, input logic [7:0] b);
        applyStimulus(toB, MESSAGE, b);
        modelByte(b);
    endtask

    task automatic measureBusy(input bit toB, output int cycles);
        cycles = 0;
        while (!(toB ? readyB : readyA) && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic sendTail(input bit toB, input string tag);
        int cycles = 0;
        applyStimulus(toB, TAIL, 8'h00);
        modelTail();
        checkOutput({tag, "ClearOnTail"}, 128'(toB ? dreadyB : dreadyA), 128'(0));
        while (!(toB ? dreadyB : dreadyA) && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "Latency"}, 128'(cycles), 128'(toB ? LAT_B : LAT_A));
        checkOutput({tag, "Digest"}, toB ? digestB : 128'(digestA), modelDigest());
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]   abc [3];
        logic [127:0] keptDigest;
        int           busy;

        abc = '{8'h61, 8'h62, 8'h63};
        rstnA = 1'b0; rstnB = 1'b0;
        validA = 1'b0; validB = 1'b0;
        cmdA = 2'b00; cmdB = 2'b00;
        byteA = 8'h00; byteB = 8'h00;
        buildSbox();

        #12;
        checkOutput("rstReadyA", 128'(readyA), 128'(1));
        checkOutput("rstDreadyA", 128'(dreadyA), 128'(0));
        checkOutput("rstDigestA", 128'(digestA), 128'(0));
        checkOutput("rstReadyB", 128'(readyB), 128'(1));
        checkOutput("rstDigestB", digestB, 128'(0));
        @(negedge clk);
        rstnA = 1'b1; rstnB = 1'b1;

        // Empty message: only HEAD and TAIL.
        modelInit(8, 32);
        applyStimulus(1'b0, HEAD, 8'h00);
        sendTail(1'b0, "empty");
`ifndef LIGHT_HASH_LEN_PAD_EN
        checkOutput("emptyIsIv", 128'(digestA), 128'h8675645342312_00F);
`endif

        // "abc": each byte keeps msg_ready low for exactly N_ROUNDS cycles.
        modelInit(8, 32);
        applyStimulus(1'b0, HEAD, 8'h00);
        for (int i = 0; i < 3; i++) begin
            sendByte(1'b0, abc[i]);
            measureBusy(1'b0, busy);
            checkOutput("abcBusy", 128'(busy), 128'(32));
        end
        sendTail(1'b0, "abc");

        // Reserved commands between bytes, then RSVD and HEAD while in DONE.
        modelInit(8, 32);
        applyStimulus(1'b0, HEAD, 8'h00);
        sendByte(1'b0, 8'h68);
        applyStimulus(1'b0, RSVD, 8'hFF);
        sendByte(1'b0, 8'h69);
        applyStimulus(1'b0, RSVD, 8'hEE);
        sendTail(1'b0, "rsvd");
        keptDigest = modelDigest();
        applyStimulus(1'b0, RSVD, 8'h00);
        checkOutput("rsvdInDoneDigest", 128'(digestA), keptDigest);
        applyStimulus(1'b0, HEAD, 8'h00);
        checkOutput("headClearsReady", 128'(dreadyA), 128'(0));
        checkOutput("headKeepsDigest", 128'(digestA), keptDigest);

        // msg_valid held high through ABSORB with a changing byte must not absorb extra bytes.
        modelInit(8, 32);
        applyStimulus(1'b0, HEAD, 8'h00);
        @(negedge clk);
        validA = 1'b1; cmdA = MESSAGE; byteA = 8'h71;
        @(posedge clk);
        #1;
        busy = 0;
        @(negedge clk);
        while (!readyA && busy < 100) begin
            byteA = 8'($urandom);
            @(negedge clk);
            busy++;
        end
        validA = 1'b0;
        modelByte(8'h71);
        checkOutput("heldBusy", 128'(busy), 128'(32));
        sendTail(1'b0, "held");

        // Asynchronous reset in the middle of ABSORB.
        applyStimulus(1'b0, HEAD, 8'h00);
        applyStimulus(1'b0, MESSAGE, 8'h55);
        repeat (5) @(posedge clk);
        #2;
        rstnA = 1'b0;
        #1;
        checkOutput("midRstReady", 128'(readyA), 128'(1));
        checkOutput("midRstDready", 128'(dreadyA), 128'(0));
        checkOutput("midRstDigest", 128'(digestA), 128'(0));
        @(negedge clk);
        rstnA = 1'b1;
        modelInit(8, 32);
        applyStimulus(1'b0, HEAD, 8'h00);
        sendByte(1'b0, 8'h78);
        sendTail(1'b0, "afterRst");

        // 16 lanes, 4 rounds: 300 bytes straight after reset (no HEAD), counter wraps to 44.
        modelInit(16, 4);
        for (int i = 0; i < 300; i++) sendByte(1'b1, 8'(i * 7 + 3));
        sendTail(1'b1, "long300");

        // A byte accepted in DONE keeps absorbing from the current state.
        sendByte(1'b1, 8'hA5);
        sendTail(1'b1, "continue");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
